// File: rtl/collect_2x1_rr_fifo_seq_pkg.sv
// Shared constants and helpers for the 2:1 round-robin collector.
package collect_2x1_rr_fifo_seq_pkg;

    localparam int unsigned BRANCH_LOW  = 0;
    localparam int unsigned BRANCH_HIGH = 1;

    // Pointer width for a power-of-two depth (log2).
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/collect_2x1_rr_fifo_seq_fifo.sv
// Show-ahead synchronous FIFO; writes to a full FIFO and reads from an empty one are ignored.
module fifo_sync_simple_seq
    import collect_2x1_rr_fifo_seq_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_WIDTH  = ptr_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [PTR_WIDTH:0]    count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  wr_do;
    logic                  rd_do;

    assign full    = (count == (PTR_WIDTH+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign wr_do   = wr_en & ~full;
    assign rd_do   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_do) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (rd_do) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            case ({wr_do, rd_do})
                2'b10:   count <= count + (PTR_WIDTH+1)'(1);
                2'b01:   count <= count - (PTR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_do) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/collect_2x1_rr_fifo_seq.sv
// Buffers the two distribute-switch branches and serializes them onto one
// ready/valid output with round-robin arbitration.
module collect_2x1_rr_fifo_seq
    import collect_2x1_rr_fifo_seq_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_WIDTH  = ptr_width(FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              i_valid,
    input  logic [2*DATA_WIDTH-1:0] i_data_bus,
    input  logic                    i_en,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data_bus,
    output logic                    o_branch,
    input  logic                    i_ready,
    output logic [1:0]              o_almost_full,
    output logic [1:0]              o_overflow
);

    logic [DATA_WIDTH-1:0] head [2];
    logic [PTR_WIDTH:0]    cnt  [2];
    logic [1:0]            full;
    logic [1:0]            empty;
    logic [1:0]            wr_req;
    logic [1:0]            rd_en;
    logic                  load;
    logic                  grant;
    logic                  last_grant;

    assign wr_req = {2{i_en}} & i_valid;
    assign load   = i_en & (~o_valid | i_ready) & (|(~empty));

    for (genvar k = 0; k < 2; k++) begin : g_branch
        fifo_sync_simple_seq #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_req[k]),
            .wr_data (i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
            .rd_en   (rd_en[k]),
            .rd_data (head[k]),
            .count   (cnt[k]),
            .full    (full[k]),
            .empty   (empty[k])
        );

        assign rd_en[k]         = load & (grant == 1'(k));
        assign o_almost_full[k] = (cnt[k] >= (PTR_WIDTH+1)'(FIFO_DEPTH - 1));
    end

    // Sole requester wins; on a tie the branch that was not granted last wins.
    always_comb begin
        grant = 1'(BRANCH_LOW);
        if (!empty[BRANCH_HIGH] && (empty[BRANCH_LOW] || last_grant == 1'(BRANCH_LOW)))
            grant = 1'(BRANCH_HIGH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            o_branch   <= 1'(BRANCH_LOW);
            o_overflow <= 2'b00;
            last_grant <= 1'(BRANCH_HIGH);
        end else begin
            o_overflow <= o_overflow | (wr_req & full);
            if (load) begin
                o_valid    <= 1'b1;
                o_data_bus <= head[grant];
                o_branch   <= grant;
                last_grant <= grant;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
